// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding two requesters' multi-byte frames to one UART TX.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BYTES   = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            REQ_A,
    input  logic                            REQ_B,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] DATA_A,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] DATA_B,
    input  logic [$clog2(MAX_BYTES)-1:0]    LEN_A,
    input  logic [$clog2(MAX_BYTES)-1:0]    LEN_B,
    output logic                            GNT_A,
    output logic                            GNT_B,
    output logic [DATA_WIDTH-1:0]           TX_P_DATA,
    output logic                            TX_DATA_VALID,
    input  logic                            TX_BUSY,
    output logic                            SCHED_BUSY,
    output logic                            DONE,
    output logic                            ERR
);
    localparam int LW = $clog2(MAX_BYTES);
    localparam int FW = DATA_WIDTH * MAX_BYTES;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BYTES - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state;
    logic [FW-1:0] frame;
    logic [LW-1:0] left;
    logic [CW-1:0] ack_cnt;
    logic          last_b;
    logic          pick_a;
    logic [LW-1:0] len_sel;

    // A wins unless B alone is asking, or both ask and A was served last
    assign pick_a  = REQ_A && (!REQ_B || last_b);
    assign len_sel = pick_a ? LEN_A : LEN_B;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            frame         <= '0;
            left          <= '0;
            ack_cnt       <= '0;
            last_b        <= 1'b1;
            GNT_A         <= 1'b0;
            GNT_B         <= 1'b0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            SCHED_BUSY    <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            GNT_A         <= 1'b0;
            GNT_B         <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            case (state)
                IDLE: if (REQ_A || REQ_B) begin
                    GNT_A      <= pick_a;
                    GNT_B      <= !pick_a;
                    last_b     <= !pick_a;
                    frame      <= pick_a ? DATA_A : DATA_B;
                    left       <= (len_sel > LEN_MAX) ? LEN_MAX : len_sel;
                    SCHED_BUSY <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: if (!TX_BUSY) begin
                    TX_DATA_VALID <= 1'b1;
                    TX_P_DATA     <= frame[DATA_WIDTH-1:0];
                    ack_cnt       <= '0;
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: if (TX_BUSY) begin
                    state <= WAIT_DONE;
                end else if (ack_cnt == ACK_LAST) begin
                    ERR        <= 1'b1;
                    SCHED_BUSY <= 1'b0;
                    state      <= IDLE;
                end else begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
                WAIT_DONE: if (!TX_BUSY) begin
                    if (left != '0) begin
                        frame <= frame >> DATA_WIDTH;
                        left  <= left - 1'b1;
                        state <= ISSUE;
                    end else begin
                        DONE       <= 1'b1;
                        SCHED_BUSY <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
